// File: rtl/fp_mult_pkg.sv
// Shared definitions for the fp_mult byte-serial multiplier and its feeder:
// transfer sizes, feeder FSM states and a few FP64 reference encodings.
package fp_mult_pkg;

  localparam int OPERAND_BYTES = 16;
  localparam int RESULT_BYTES  = 8;
  localparam int FP64_W        = 64;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'd0,
    FS_SEND     = 3'd1,
    FS_WAIT_RES = 3'd2,
    FS_DRAIN    = 3'd3,
    FS_GAP      = 3'd4,
    FS_HALT     = 3'd5
  } feeder_state_e;

  localparam logic [FP64_W-1:0] FP64_ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [FP64_W-1:0] FP64_TWO  = 64'h4000_0000_0000_0000;
  localparam logic [FP64_W-1:0] FP64_PINF = 64'h7FF0_0000_0000_0000;
  localparam logic [FP64_W-1:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/fp_op_fifo.sv
// Small synchronous FIFO with register-array storage; the head entry is
// presented straight from its storage register (show-ahead).
module fp_op_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s  = push_i && !full_o;
  assign pop_ok_s   = pop_i && !empty_o;
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == {(AW + 1){1'b0}});
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_ok_s);
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok_s);
      count_q  <= count_q + (AW + 1)'(push_ok_s) - (AW + 1)'(pop_ok_s);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fp_mult_feeder.sv
// Streams queued operand pairs into fp_mult as 16 ENABLE-qualified bytes and
// supervises its 8-byte READY burst; any protocol fault latches and halts.
module fp_mult_feeder
  import fp_mult_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP64_W-1:0] in_a,
  input  logic [FP64_W-1:0] in_b,
  output logic              ENABLE,
  output logic [7:0]        DATA_IN,
  input  logic              MULT_READY,
  output logic              busy,
  output logic              op_done,
  output logic              timeout_err,
  output logic              proto_err,
  output logic [15:0]       ops_done
);

  localparam int OPW   = 2 * FP64_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [3:0]       LAST_BYTE = 4'(OPERAND_BYTES - 1);
  localparam logic [2:0]       PRE_LAST  = 3'(RESULT_BYTES - 2);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT);
  // Fires on the (TIMEOUT-1)th silent cycle so the flag lands TIMEOUT cycles after the last beat.
  localparam logic [WD_W-1:0]  WD_FIRE   = WD_W'(TIMEOUT - 2);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  feeder_state_e    state_q,   state_d;
  logic [OPW-1:0]   shift_q,   shift_d;
  logic [3:0]       byte_q,    byte_d;
  logic [2:0]       rcnt_q,    rcnt_d;
  logic             rlast_q,   rlast_d;
  logic [WD_W-1:0]  wdog_q,    wdog_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic             enable_q,  enable_d;
  logic [7:0]       data_q,    data_d;
  logic             ready_q,   ready_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             tmo_q,     tmo_d;
  logic             proto_q,   proto_d;
  logic [15:0]      ops_q,     ops_d;

  logic             push_s;
  logic             pop_s;
  logic [OPW-1:0]   head_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] count_next_s;

  assign push_s       = in_valid && ready_q && !full_s;
  assign count_next_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);

  fp_op_fifo #(
    .WIDTH (OPW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .push_i      (push_s),
    .push_data_i ({in_a, in_b}),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .count_o     (count_s)
  );

  // Next-state and next-output computation for the feeder FSM.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    rcnt_d   = rcnt_q;
    rlast_d  = rlast_q;
    wdog_d   = wdog_q;
    gap_d    = gap_q;
    enable_d = enable_q;
    data_d   = data_q;
    done_d   = 1'b0;
    tmo_d    = tmo_q;
    proto_d  = proto_q;
    ops_d    = ops_q;
    pop_s    = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (MULT_READY) begin
          proto_d = 1'b1;
          state_d = FS_HALT;
        end else if (!empty_s) begin
          pop_s    = 1'b1;
          data_d   = head_s[OPW-1 -: 8];
          shift_d  = {head_s[OPW-9:0], 8'h00};
          enable_d = 1'b1;
          byte_d   = 4'd0;
          state_d  = FS_SEND;
        end else begin
          state_d = FS_IDLE;
        end
      end
      FS_SEND: begin
        if (MULT_READY) begin
          proto_d  = 1'b1;
          enable_d = 1'b0;
          data_d   = 8'h00;
          state_d  = FS_HALT;
        end else if (byte_q == LAST_BYTE) begin
          enable_d = 1'b0;
          data_d   = 8'h00;
          wdog_d   = {WD_W{1'b0}};
          state_d  = FS_WAIT_RES;
        end else begin
          data_d  = shift_q[OPW-1 -: 8];
          shift_d = {shift_q[OPW-9:0], 8'h00};
          byte_d  = byte_q + 4'd1;
        end
      end
      FS_WAIT_RES: begin
        if (MULT_READY) begin
          rcnt_d  = 3'd1;
          rlast_d = 1'b0;
          state_d = FS_DRAIN;
        end else if (wdog_q == WD_FIRE) begin
          tmo_d   = 1'b1;
          state_d = FS_HALT;
        end else if (wdog_q != WD_MAX) begin
          wdog_d = wdog_q + WD_W'(1);
        end else begin
          wdog_d = WD_MAX;
        end
      end
      FS_DRAIN: begin
        if (!MULT_READY) begin
          proto_d = 1'b1;
          state_d = FS_HALT;
        end else if (rlast_q) begin
          done_d  = 1'b1;
          ops_d   = ops_q + 16'd1;
          gap_d   = {GAP_W{1'b0}};
          state_d = FS_GAP;
        end else begin
          rcnt_d  = rcnt_q + 3'd1;
          rlast_d = (rcnt_q == PRE_LAST);
        end
      end
      FS_GAP: begin
        if (MULT_READY) begin
          proto_d = 1'b1;
          state_d = FS_HALT;
        end else if (gap_q == GAP_LAST) begin
          state_d = FS_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      FS_HALT: begin
        state_d = FS_HALT;
      end
      default: begin
        enable_d = 1'b0;
        state_d  = FS_HALT;
      end
    endcase
    busy_d  = (state_d != FS_IDLE);
    ready_d = (count_next_s != FULL_CNT) && (state_d != FS_HALT);
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= FS_IDLE;
      shift_q  <= {OPW{1'b0}};
      byte_q   <= 4'd0;
      rcnt_q   <= 3'd0;
      rlast_q  <= 1'b0;
      wdog_q   <= {WD_W{1'b0}};
      gap_q    <= {GAP_W{1'b0}};
      enable_q <= 1'b0;
      data_q   <= 8'h00;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      proto_q  <= 1'b0;
      ops_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      rcnt_q   <= rcnt_d;
      rlast_q  <= rlast_d;
      wdog_q   <= wdog_d;
      gap_q    <= gap_d;
      enable_q <= enable_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      proto_q  <= proto_d;
      ops_q    <= ops_d;
    end
  end

  assign in_ready    = ready_q;
  assign ENABLE      = enable_q;
  assign DATA_IN     = data_q;
  assign busy        = busy_q;
  assign op_done     = done_q;
  assign timeout_err = tmo_q;
  assign proto_err   = proto_q;
  assign ops_done    = ops_q;

endmodule
